// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - opcodes, status codes and FSM states shared by the UART command engine
package uart_cmd_pkg;

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'hE1;
  localparam logic [7:0] ST_UNKNOWN = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_WDATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND,
    S_RST_PULSE,
    S_STATUS
  } state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_RESET) || (op == OP_WRITE) || (op == OP_READ) || (op == OP_PING);
  endfunction

endpackage

// File: rtl/uart_cmd_reset_pulse.sv
// rtl/uart_cmd_reset_pulse.sv - fixed-width reset pulse generator with start strobe and done flag
module uart_cmd_reset_pulse #(
  parameter int RESET_CYCLES = 200000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      pulse <= 1'b1;
      cnt   <= '0;
    end else if (pulse) begin
      if (cnt == LAST) begin
        pulse <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // done marks the final high cycle so the caller can leave in step with the pulse
  assign done = pulse && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_engine.sv
// rtl/uart_cmd_engine.sv - framed UART command engine; UART_CMD_TIMEOUT_EN enables inter-byte timeout
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int RESET_CYCLES   = 200000,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int ADDR_W        = 8 * ADDR_BYTES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              reset_out,
  output logic              rx_overrun,
  output logic              busy
);

  state_e            state, state_nxt;
  logic [7:0]        opcode_q;
  logic [7:0]        len_q;
  logic [7:0]        arg_cnt;
  logic [7:0]        status_q;
  logic [7:0]        rdata_q;
  logic [7:0]        wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              last_q;
  logic              overrun_q;
  logic              rst_start;
  logic              rst_done;
  logic              timeout_hit;
  logic              args_done;

  assign args_done = (arg_cnt == 8'(ADDR_BYTES));

  uart_cmd_reset_pulse #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_pulse (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (rst_start),
    .pulse  (reset_out),
    .done   (rst_done)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  // the wait after the last write byte is not host idle time, so it is not timed
  assign in_frame = (state == S_ARGS) || ((state == S_WDATA) && !last_q);

  always_ff @(posedge clock) begin
    if (!reset_n || !in_frame || rx_valid) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rst_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            OP_RESET: begin
              state_nxt = S_RST_PULSE;
              rst_start = 1'b1;
            end
            OP_WRITE, OP_READ: state_nxt = S_ARGS;
            default:           state_nxt = S_STATUS;
          endcase
        end
      end
      S_ARGS: begin
        if (timeout_hit) begin
          state_nxt = S_STATUS;
        end else if (rx_valid && args_done) begin
          state_nxt = (opcode_q == OP_WRITE) ? S_WDATA : S_RD_ISSUE;
        end
      end
      S_WDATA: begin
        if (timeout_hit || (we_q && last_q)) begin
          state_nxt = S_STATUS;
        end
      end
      S_RD_ISSUE: state_nxt = S_RD_WAIT;
      S_RD_WAIT:  state_nxt = S_RD_SEND;
      S_RD_SEND: begin
        if (tx_ready) begin
          state_nxt = (len_q == 8'd0) ? S_STATUS : S_RD_ISSUE;
        end
      end
      S_RST_PULSE: begin
        if (rst_done) begin
          state_nxt = S_STATUS;
        end
      end
      S_STATUS: begin
        if (tx_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opcode_q  <= 8'd0;
      len_q     <= 8'd0;
      arg_cnt   <= 8'd0;
      status_q  <= 8'd0;
      rdata_q   <= 8'd0;
      wdata_q   <= 8'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            opcode_q <= rx_byte;
            addr_q   <= '0;
            arg_cnt  <= 8'd0;
            last_q   <= 1'b0;
            status_q <= is_known_op(rx_byte) ? ST_OK : ST_UNKNOWN;
          end
        end
        S_ARGS: begin
          if (rx_valid) begin
            if (args_done) begin
              len_q <= rx_byte;
            end else begin
              addr_q  <= ADDR_W'({addr_q, rx_byte});
              arg_cnt <= arg_cnt + 8'd1;
            end
          end
        end
        S_WDATA: begin
          // the address advances once its write strobe has gone out
          if (we_q) begin
            addr_q <= addr_q + 1'b1;
          end
          if (rx_valid && !last_q) begin
            we_q    <= 1'b1;
            wdata_q <= rx_byte;
            if (len_q == 8'd0) begin
              last_q <= 1'b1;
            end else begin
              len_q <= len_q - 8'd1;
            end
          end
        end
        S_RD_WAIT: rdata_q <= mem_rdata;
        S_RD_SEND: begin
          if (tx_ready) begin
            addr_q <= addr_q + 1'b1;
            if (len_q != 8'd0) begin
              len_q <= len_q - 8'd1;
            end
          end
        end
        default: ;
      endcase

      if (timeout_hit) begin
        status_q <= ST_TIMEOUT;
      end

      if (rx_valid && ((state == S_RD_ISSUE) || (state == S_RD_WAIT) || (state == S_RD_SEND) ||
                       (state == S_RST_PULSE) || (state == S_STATUS) ||
                       ((state == S_WDATA) && last_q))) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign mem_re     = (state == S_RD_ISSUE);
  assign tx_valid   = (state == S_STATUS) || (state == S_RD_SEND);
  assign tx_byte    = (state == S_RD_SEND) ? rdata_q : status_q;
  assign rx_overrun = overrun_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb/tb_uart_cmd_engine.sv - scoreboard bench for uart_cmd_engine, extra timeout case with UART_CMD_TIMEOUT_EN
module tb_uart_cmd_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'hDE;
  logic        reset_out;
  logic        rx_overrun;
  logic        busy;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  uart_cmd_engine #(
    .ADDR_BYTES    (2),
    .RESET_CYCLES  (16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .reset_out (reset_out),
    .rx_overrun(rx_overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // read data appears only in the cycle after mem_re
  always @(posedge clock) begin
    mem_rdata <= mem_re ? mem_model(mem_addr) : 8'hDE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (hold_q) chk("tx_stable", 32'(tx_byte), 32'(hold_byte));
      if (mem_we) begin
        n_assert++;
        assert (exp_wr.size() != 0) else begin
          n_fail++;
          $error("FAIL wr_unexpected: observed addr %h data %h expected none", mem_addr, mem_wdata);
        end
        if (exp_wr.size() != 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", 32'(mem_wdata), 32'(w.data));
        end
      end
      if (tx_valid && tx_ready) begin
        n_assert++;
        assert (exp_tx.size() != 0) else begin
          n_fail++;
          $error("FAIL tx_unexpected: observed %h expected none", tx_byte);
        end
        if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
      end
      hold_q    = tx_valid && !tx_ready;
      hold_byte = tx_byte;
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!tx_valid && n < 100) begin
      tick();
      n++;
    end
    chk("tx_wait", 32'(tx_valid), 32'd1);
  endtask

  task automatic take_tx();
    wait_tx();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reset_out", 32'(reset_out), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // RESET opcode: pulse width then status
    exp_tx.push_back(8'h00);
    send(8'h00);
    n = 0;
    while (reset_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("reset_width", 32'(n), 32'd16);
    chk("reset_status_lat", 32'(tx_valid), 32'd1);
    take_tx();

    // PING
    exp_tx.push_back(8'h00);
    send(8'h03);
    chk("ping_lat", 32'(tx_valid), 32'd1);
    chk("ping_busy", 32'(busy), 32'd1);
    take_tx();

    // WRITE 0x1234, three bytes back to back
    exp_wr.push_back('{16'h1234, 8'hAA});
    exp_wr.push_back('{16'h1235, 8'hBB});
    exp_wr.push_back('{16'h1236, 8'hCC});
    exp_tx.push_back(8'h00);
    send(8'h01); send(8'h12); send(8'h34); send(8'h02);
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("wr_we_lat", 32'(mem_we), 32'd1);
    tick();
    chk("wr_status_lat", 32'(tx_valid), 32'd1);
    take_tx();

    // WRITE across the top of the address space, with idle gaps
    exp_wr.push_back('{16'hFFFF, 8'h11});
    exp_wr.push_back('{16'h0000, 8'h22});
    exp_tx.push_back(8'h00);
    send(8'h01); tick(); send(8'hFF); send(8'hFF); tick(); tick();
    send(8'h01); send(8'h11); repeat (3) tick(); send(8'h22);
    take_tx();

    // READ 0x0010 len 1 under backpressure
    exp_tx.push_back(mem_model(16'h0010));
    exp_tx.push_back(mem_model(16'h0011));
    exp_tx.push_back(8'h00);
    send(8'h02); send(8'h00); send(8'h10); send(8'h01);
    chk("rd_re_lat", 32'(mem_re), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h0010);
    for (int i = 0; i < 3; i++) begin
      wait_tx();
      repeat (5) tick();
      chk("rd_hold_valid", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      if (i == 0) chk("rd_re_after_hs", 32'(mem_re), 32'd1);
    end

    // unknown opcode, then a byte dropped during STATUS backpressure
    exp_tx.push_back(8'hEE);
    send(8'h7F);
    chk("unk_lat", 32'(tx_valid), 32'd1);
    chk("unk_byte", 32'(tx_byte), 32'hEE);
    chk("ovr_before", 32'(rx_overrun), 32'd0);
    send(8'h03);
    chk("ovr_set", 32'(rx_overrun), 32'd1);
    take_tx();
    repeat (4) tick();
    chk("ovr_dropped_tx", 32'(tx_valid), 32'd0);
    chk("ovr_dropped_busy", 32'(busy), 32'd0);
    chk("ovr_sticky", 32'(rx_overrun), 32'd1);

    // reset_n during the reset pulse
    send(8'h00);
    repeat (3) tick();
    chk("mid_pulse_high", 32'(reset_out), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mid_pulse_drop", 32'(reset_out), 32'd0);
    chk("ovr_cleared", 32'(rx_overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // reset_n during READ: frame abandoned, nothing transmitted
    send(8'h02); send(8'h00); send(8'h20); send(8'h03);
    wait_tx();
    chk("mid_read_byte", 32'(tx_byte), 32'(mem_model(16'h0020)));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_read_idle_tx", 32'(tx_valid), 32'd0);
    chk("mid_read_idle_busy", 32'(busy), 32'd0);
    tx_ready = 1'b1;
    repeat (5) tick();
    tx_ready = 1'b0;
    chk("mid_read_no_tx", 32'(tx_valid), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    // WRITE stalls after one address byte
    exp_tx.push_back(8'hE1);
    send(8'h01); send(8'h12);
    n = 0;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd64);
    take_tx();
`endif

    tick();
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
